// File: rtl/vec_mac_unit.sv
// vec_mac_unit
//   Signed vector multiply-accumulate. Each enabled cycle takes one packed
//   A word and one packed B word (LANES two's-complement lanes each),
//   multiplies the lanes pairwise and sums the products. Over LEN enabled
//   words it accumulates one dot product, which is presented on result
//   together with a one-cycle done pulse.
//
//   Pipeline:
//     stage 1: per-lane products, word counter, valid/first/last tags
//     stage 2: lane sum and accumulate; write result on the last word
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     clr     synchronous abort: flush pipeline, restart vector count
//     en      a/b valid this cycle
//     a, b    packed operands, lane i = x[i*LANE_BITS +: LANE_BITS]
//     result  last completed dot product (signed, ACC_BITS)
//     done    one-cycle pulse, result just updated
//     busy    vector partially accumulated or word in flight
//
//   Build option:
//     VEC_MAC_SAT_EN  defined   -> every accumulate step saturates to the
//                                  signed ACC_BITS range
//                     undefined -> every accumulate step wraps
module vec_mac_unit #(
    parameter int LANES     = 8,
    parameter int LANE_BITS = 8,
    parameter int LEN       = 8,
    parameter int ACC_BITS  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic [LANES*LANE_BITS-1:0]    a,
    input  logic [LANES*LANE_BITS-1:0]    b,
    output logic signed [ACC_BITS-1:0]    result,
    output logic                          done,
    output logic                          busy
);

    localparam int PW = 2 * LANE_BITS;                 // product width
    localparam int SW = PW + $clog2(LANES);            // lane-sum width
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;   // counter width
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    // ------------------------------------------------------------------
    // Stage 1: lane products and word tags
    // ------------------------------------------------------------------
    logic [CW-1:0]        cnt;
    logic signed [PW-1:0] p [LANES];
    logic                 v1;
    logic                 first1;
    logic                 last1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            v1     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                p[i] <= '0;
            end
        end else begin
            // clr drops any word presented in the same cycle
            v1 <= en & ~clr;
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    p[i] <= $signed(a[i*LANE_BITS +: LANE_BITS]) *
                            $signed(b[i*LANE_BITS +: LANE_BITS]);
                end
                first1 <= (cnt == '0);
                last1  <= (cnt == CNT_LAST);
                cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: lane sum, accumulate step
    // ------------------------------------------------------------------
    logic signed [SW-1:0]       s;
    logic signed [SW-1:0]       p_ext;
    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] acc_next;

    always_comb begin
        s     = '0;
        p_ext = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            p_ext = p[i];             // sign-extends to SW
            s     = s + p_ext;
        end
    end

`ifdef VEC_MAC_SAT_EN
    localparam int AW = ((ACC_BITS > SW) ? ACC_BITS : SW) + 1;
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};

    logic signed [AW-1:0] base_w;
    logic signed [AW-1:0] wide;

    // The AW-bit sum cannot overflow, so one compare against each rail
    // is enough to clamp.
    always_comb begin
        base_w = first1 ? '0 : AW'(acc);
        wide   = base_w + AW'(s);
        if (wide > SAT_MAX) begin
            acc_next = {1'b0, {(ACC_BITS-1){1'b1}}};
        end else if (wide < SAT_MIN) begin
            acc_next = {1'b1, {(ACC_BITS-1){1'b0}}};
        end else begin
            acc_next = wide[ACC_BITS-1:0];
        end
    end
`else
    // Wrapping the widened sum to ACC_BITS equals adding directly at
    // ACC_BITS, so the wrap build does the add at the final width.
    logic signed [ACC_BITS-1:0] base_a;

    always_comb begin
        base_a   = first1 ? '0 : acc;
        acc_next = base_a + ACC_BITS'(s);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else if (clr) begin
            // in-flight last word is discarded; result is kept
            acc  <= '0;
            done <= 1'b0;
        end else begin
            done <= v1 & last1;
            if (v1) begin
                if (last1) begin
                    result <= acc_next;
                    acc    <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

    assign busy = v1 | (cnt != '0);

endmodule

// File: tb/tb_vec_mac_unit.sv
// tb_vec_mac_unit
//   Self-checking bench for vec_mac_unit. A 32-bit accumulator instance
//   carries the main scenarios; a 16-bit instance sharing the same inputs
//   covers accumulator overflow. Expected dot products come from a plain
//   arithmetic model over the stored operand words.
module tb_vec_mac_unit;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clr = 1'b0;
    logic               en = 1'b0;
    logic [63:0]        a = '0;
    logic [63:0]        b = '0;
    logic signed [31:0] result;
    logic               done;
    logic               busy;
    logic signed [15:0] result16;
    logic               done16;
    logic               busy16;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0]        va [8];
    logic [63:0]        vb [8];
    logic signed [31:0] done_q [$];
    logic signed [15:0] done16_q [$];

    always #5 clk = ~clk;

    vec_mac_unit #(
        .LANES(8), .LANE_BITS(8), .LEN(8), .ACC_BITS(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .a(a), .b(b),
        .result(result), .done(done), .busy(busy)
    );

    vec_mac_unit #(
        .LANES(8), .LANE_BITS(8), .LEN(8), .ACC_BITS(16)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .a(a), .b(b),
        .result(result16), .done(done16), .busy(busy16)
    );

    // Record every completed result shortly after the edge that produced it
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_q.push_back(result);
        if (done16 === 1'b1) done16_q.push_back(result16);
    end

    // ---------------- reference model ----------------
    function automatic longint lane_dot(input logic [63:0] x, input logic [63:0] y);
        longint t = 0;
        logic signed [7:0] xa, ya;
        for (int i = 0; i < 8; i++) begin
            xa = x[i*8 +: 8];
            ya = y[i*8 +: 8];
            t += longint'(xa) * longint'(ya);
        end
        return t;
    endfunction

    function automatic longint ref_vec(input int bits);
        longint acc = 0;
        longint lo, hi, span;
        span = 64'sd1 <<< bits;
        hi   = (64'sd1 <<< (bits - 1)) - 1;
        lo   = -(64'sd1 <<< (bits - 1));
        for (int w = 0; w < 8; w++) begin
            acc = acc + lane_dot(va[w], vb[w]);
`ifdef VEC_MAC_SAT_EN
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
`else
            acc = acc & (span - 1);
            if (acc > hi) acc = acc - span;
`endif
        end
        return acc;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en  = 1'b0;
            clr = 1'b0;
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
        end
    endtask

    task automatic word(input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        en  = 1'b1;
        clr = 1'b0;
        a   = x;
        b   = y;
    endtask

    // gap_mode: 0 = consecutive, 1 = idle between words, 2 = random idles
    task automatic send_vec(input int gap_mode);
        for (int w = 0; w < 8; w++) begin
            if (gap_mode == 1 && w > 0) idle(1);
            else if (gap_mode == 2) idle(int'($urandom_range(0, 2)));
            word(va[w], vb[w]);
        end
    endtask

    task automatic fill_const(input logic [7:0] x, input logic [7:0] y);
        for (int i = 0; i < 8; i++) begin
            va[i] = {8{x}};
            vb[i] = {8{y}};
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 8; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
        end
    endtask

    task automatic wait_q(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
        if (done_q.size() >= n) ok = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        longint exp;
        #12;
        n_cmp++; if (result !== 32'sd0) begin n_err++; $display("FAIL reset_result: got %0d expected 0", result); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;

        fill_rand();
        exp = ref_vec(32);
        done_q.delete();
        send_vec(0);
        wait_q(1, 10, ok);
        n_cmp++; if (!ok || longint'(done_q[0]) !== exp) begin n_err++; $display("FAIL pre_reset_vec: got %0d (seen=%0d) expected %0d", ok ? done_q[0] : 0, ok, exp); end

        // three words, then an asynchronous reset mid-cycle
        fill_rand();
        for (int w = 0; w < 3; w++) word(va[w], vb[w]);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (result !== 32'sd0) begin n_err++; $display("FAIL midvec_reset_result: got %0d expected 0", result); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midvec_reset_done: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midvec_reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;

        fill_rand();
        exp = ref_vec(32);
        done_q.delete();
        send_vec(0);
        wait_q(1, 10, ok);
        n_cmp++; if (!ok || longint'(done_q[0]) !== exp) begin n_err++; $display("FAIL post_reset_vec: got %0d (seen=%0d) expected %0d", ok ? done_q[0] : 0, ok, exp); end
    endtask

    task automatic test_latency();
        fill_const(8'd1, 8'd2);
        send_vec(0);
        // one cycle after the last sample: stage 2 not yet written
        idle(1);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL lat_early_done: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lat_busy_inflight: got %b expected 1", busy); end
        idle(1);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL lat_done: got %b expected 1", done); end
        n_cmp++; if (result !== 32'sd128) begin n_err++; $display("FAIL lat_result: got %0d expected 128", result); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lat_busy_idle: got %b expected 0", busy); end
        idle(1);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL lat_done_width: got %b expected 0", done); end
        n_cmp++; if (result !== 32'sd128) begin n_err++; $display("FAIL lat_result_hold: got %0d expected 128", result); end
    endtask

    task automatic test_signed();
        bit ok;
        fill_const(8'h80, 8'h7F);
        done_q.delete();
        send_vec(0);
        wait_q(1, 10, ok);
        n_cmp++; if (!ok || done_q[0] !== -32'sd1040384) begin n_err++; $display("FAIL signed_vec: got %0d (seen=%0d) expected -1040384", ok ? done_q[0] : 0, ok); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        longint e1, e2;
        fill_const(8'd1, 8'd2);
        e1 = ref_vec(32);
        done_q.delete();
        send_vec(1);
        fill_const(8'd3, 8'd1);
        e2 = ref_vec(32);
        send_vec(0);
        wait_q(2, 12, ok);
        idle(2);
        n_cmp++; if (done_q.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d expected 2", done_q.size()); end
        n_cmp++; if (!ok || longint'(done_q[0]) !== e1) begin n_err++; $display("FAIL b2b_first: got %0d expected %0d", ok ? done_q[0] : 0, e1); end
        n_cmp++; if (!ok || longint'(done_q[1]) !== e2) begin n_err++; $display("FAIL b2b_second: got %0d expected %0d", ok ? done_q[1] : 0, e2); end
    endtask

    task automatic test_clr();
        bit ok;
        logic signed [31:0] prev;
        prev = result;
        fill_const(8'd5, 8'd5);
        done_q.delete();
        for (int w = 0; w < 3; w++) word(va[w], vb[w]);
        @(negedge clk);
        en  = 1'b1;
        clr = 1'b1;
        a   = va[3];
        b   = vb[3];
        idle(1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b expected 0", busy); end
        n_cmp++; if (result !== prev) begin n_err++; $display("FAIL clr_result_kept: got %0d expected %0d", result, prev); end

        fill_const(8'd1, 8'd1);
        send_vec(0);
        wait_q(1, 10, ok);
        idle(3);
        n_cmp++; if (done_q.size() !== 1) begin n_err++; $display("FAIL clr_done_count: got %0d expected 1", done_q.size()); end
        n_cmp++; if (!ok || done_q[0] !== 32'sd64) begin n_err++; $display("FAIL clr_next_vec: got %0d expected 64", ok ? done_q[0] : 0); end

        // abort while the last word sits in stage 1
        fill_const(8'd2, 8'd2);
        done_q.delete();
        send_vec(0);
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b1;
        idle(4);
        n_cmp++; if (done_q.size() !== 0) begin n_err++; $display("FAIL clr_inflight_done: got %0d pulses expected 0", done_q.size()); end
        n_cmp++; if (result !== 32'sd64) begin n_err++; $display("FAIL clr_inflight_result: got %0d expected 64", result); end
    endtask

    task automatic test_random();
        bit ok;
        longint exp [$];
        done_q.delete();
        for (int k = 0; k < 6; k++) begin
            fill_rand();
            exp.push_back(ref_vec(32));
            send_vec((k % 2 == 0) ? 2 : 0);
        end
        wait_q(6, 20, ok);
        idle(2);
        n_cmp++; if (done_q.size() !== 6) begin n_err++; $display("FAIL rand_count: got %0d expected 6", done_q.size()); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= done_q.size() || longint'(done_q[k]) !== exp[k]) begin
                n_err++;
                $display("FAIL rand_vec%0d: got %0d expected %0d", k, (k < done_q.size()) ? done_q[k] : 0, exp[k]);
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        bit ok;
        longint e32;
        logic signed [15:0] e16;
`ifdef VEC_MAC_SAT_EN
        e16 = 16'sd32767;
`else
        e16 = -16'sd16320;
`endif
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b1;
        idle(1);
        fill_const(8'h7F, 8'h7F);
        e32 = ref_vec(32);
        done_q.delete();
        done16_q.delete();
        send_vec(0);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done16_q.size() >= 1 && done_q.size() >= 1) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
        n_cmp++; if (!ok || done16_q[0] !== e16) begin n_err++; $display("FAIL ovf_acc16: got %0d expected %0d", ok ? done16_q[0] : 0, e16); end
        n_cmp++; if (!ok || longint'(done_q[0]) !== e32) begin n_err++; $display("FAIL ovf_acc32: got %0d expected %0d", ok ? done_q[0] : 0, e32); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_signed();
        test_back_to_back();
        test_clr();
        test_random();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
